// File: rtl/texture_loader.sv
`default_nettype none
// ============================================================================
// Module      : texture_loader
// Description : Streams a texture image from a host byte interface into the
//               texture unit's write port. Bytes are assembled into RGB565
//               texels, either taken directly as RGB565 little-endian pairs
//               or converted from R,G,B RGB888 triplets by truncation. Writes
//               go to sequential addresses from a base address, wrapping
//               modulo the texture size.
// Ports       : clk, rst_n            - clock, async active-low reset
//               load_start/base/count/fmt - load command (taken only when idle)
//               load_abort             - cancel the load in progress
//               byte_in/_valid/_ready  - byte stream handshake
//               tex_wr_addr/data/en    - registered texture write port
//               busy, done             - progress status (done = 1-cycle pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module texture_loader #(
  parameter int TEX_WIDTH_LOG2  = 6,
  parameter int TEX_HEIGHT_LOG2 = 6,
  parameter int TEX_SIZE        = 1 << (TEX_WIDTH_LOG2 + TEX_HEIGHT_LOG2),
  parameter int ADDR_BITS       = TEX_WIDTH_LOG2 + TEX_HEIGHT_LOG2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic [ADDR_BITS-1:0] load_base,
  input  logic [ADDR_BITS:0]   load_count,
  input  logic                 load_fmt,
  input  logic                 load_abort,
  input  logic [7:0]           byte_in,
  input  logic                 byte_in_valid,
  output logic                 byte_in_ready,
  output logic [ADDR_BITS-1:0] tex_wr_addr,
  output logic [15:0]          tex_wr_data,
  output logic                 tex_wr_en,
  output logic                 busy,
  output logic                 done
);

  localparam int               CNT_W      = ADDR_BITS + 1;
  localparam logic [CNT_W-1:0] C_TEX_SIZE = CNT_W'(TEX_SIZE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_B0    = 3'd1;
  localparam logic [2:0] S_B1    = 3'd2;
  localparam logic [2:0] S_B2    = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] base_q;
  logic [CNT_W-1:0]     count_q;
  logic                 fmt_q;
  logic [CNT_W-1:0]     idx_q;
  logic [7:0]           b0_q;       // low byte (fmt 0) or R (fmt 1)
  logic [7:0]           b1_q;       // G (fmt 1)
  logic [ADDR_BITS-1:0] wr_addr_q;
  logic [15:0]          wr_data_q;
  logic                 wr_en_q;
  logic                 done_q;

  logic                 accept;
  logic                 complete;
  logic                 last;
  logic [CNT_W-1:0]     idx_inc;
  logic [CNT_W-1:0]     count_clamped;
  logic [15:0]          texel;

  assign accept   = byte_in_valid & byte_in_ready;
  // The final byte of a texel arrives in B1 for RGB565 and in B2 for RGB888.
  assign complete = accept & (((state_q == S_B1) & ~fmt_q) | (state_q == S_B2));
  assign idx_inc  = idx_q + 1'b1;
  assign last     = (idx_inc == count_q);
  assign texel    = fmt_q ? {b0_q[7:3], b1_q[7:2], byte_in[7:3]}
                          : {byte_in, b0_q};
  assign count_clamped = (load_count > C_TEX_SIZE) ? C_TEX_SIZE : load_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over byte acceptance and completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = (load_count == '0) ? S_FLUSH : S_B0;
        end
      end
      S_B0: begin
        if (load_abort)  state_d = S_IDLE;
        else if (accept) state_d = S_B1;
      end
      S_B1: begin
        if (load_abort)     state_d = S_IDLE;
        else if (accept) begin
          if (fmt_q)        state_d = S_B2;
          else              state_d = last ? S_FLUSH : S_B0;
        end
      end
      S_B2: begin
        if (load_abort)  state_d = S_IDLE;
        else if (accept) state_d = last ? S_FLUSH : S_B0;
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State decode outputs
  always_comb begin
    byte_in_ready = 1'b0;
    busy          = (state_q != S_IDLE);
    if ((state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2)) begin
      byte_in_ready = ~load_abort;
    end
  end

  // Command latch, byte assembly and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      count_q   <= '0;
      fmt_q     <= 1'b0;
      idx_q     <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if ((state_q == S_IDLE) && load_start) begin
        base_q  <= load_base;
        count_q <= count_clamped;
        fmt_q   <= load_fmt;
        idx_q   <= '0;
        // A zero-length load completes immediately through FLUSH.
        done_q  <= (load_count == '0);
      end
      if (accept && (state_q == S_B0)) b0_q <= byte_in;
      if (accept && (state_q == S_B1)) b1_q <= byte_in;
      if (complete) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= base_q + idx_q[ADDR_BITS-1:0];   // wraps by truncation
        wr_data_q <= texel;
        idx_q     <= idx_inc;
        done_q    <= last;
      end
    end
  end

  assign tex_wr_addr = wr_addr_q;
  assign tex_wr_data = wr_data_q;
  assign tex_wr_en   = wr_en_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_texture_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_texture_loader
// Description : Directed self-checking bench for texture_loader. A per-load
//               model turns the byte stream into the expected list of
//               (address, texel) writes; every cycle the observed write port
//               and done pulse are compared against that list, and literal
//               tables pin the model on the hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_texture_loader;

  localparam int AB = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [AB-1:0] load_base = '0;
  logic [AB:0]   load_count = '0;
  logic          load_fmt = 1'b0;
  logic          load_abort = 1'b0;
  logic [7:0]    byte_in = '0;
  logic          byte_in_valid = 1'b0;
  wire           byte_in_ready;
  wire  [AB-1:0] tex_wr_addr;
  wire  [15:0]   tex_wr_data;
  wire           tex_wr_en;
  wire           busy;
  wire           done;

  texture_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_start    (load_start),
    .load_base     (load_base),
    .load_count    (load_count),
    .load_fmt      (load_fmt),
    .load_abort    (load_abort),
    .byte_in       (byte_in),
    .byte_in_valid (byte_in_valid),
    .byte_in_ready (byte_in_ready),
    .tex_wr_addr   (tex_wr_addr),
    .tex_wr_data   (tex_wr_data),
    .tex_wr_en     (tex_wr_en),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc_n = 0;
  int         done_cyc = 0;
  int         start_cyc = 0;
  bit         done_armed = 0;
  bit         saw_done = 0;
  bit         prev_done = 0;
  wr_t        exp_q[$];
  wr_t        wlog[$];
  logic [7:0] bq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  // Per-cycle comparison of the write port and done against the model.
  task automatic compare();
    wr_t w;
    cyc_n++;
    if (prev_done) chk("busy_after_done", 32'(busy), 0);
    prev_done = done;
    if (tex_wr_en) begin
      w.addr = tex_wr_addr; w.data = tex_wr_data; w.cyc = cyc_n;
      wlog.push_back(w);
      if (exp_q.size() == 0) begin
        chk("unexpected_wr_en", 32'(tex_wr_en), 0);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", 32'(tex_wr_addr), 32'(w.addr));
        chk("wr_data", 32'(tex_wr_data), 32'(w.data));
      end
    end
    if (done) begin
      chk("unexpected_done", 32'(done), 32'(done_armed));
      chk("writes_left_at_done", 32'(exp_q.size()), 0);
      done_armed = 0;
      saw_done   = 1;
      done_cyc   = cyc_n;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    compare();
  endtask

  // Run one load: build expected writes from bq, issue start, stream bytes.
  // gap>0 drops valid every gap-th cycle; abort_at>=0 aborts after that many
  // accepted bytes; restart_at>=0 pulses load_start at that stream cycle.
  task automatic run_load(input logic fmt, input logic [AB-1:0] base,
                          input logic [AB:0] cnt, input int gap,
                          input int abort_at, input int restart_at);
    int  n, bpt, ntex, k, t;
    wr_t w;
    bpt  = fmt ? 3 : 2;
    n    = (cnt > 13'd4096) ? 4096 : int'(cnt);
    ntex = (abort_at >= 0 && abort_at / bpt < n) ? abort_at / bpt : n;
    exp_q.delete();
    for (int i = 0; i < ntex; i++) begin
      w.addr = 12'((int'(base) + i) % 4096);
      if (fmt) w.data = {bq[3*i][7:3], bq[3*i+1][7:2], bq[3*i+2][7:3]};
      else     w.data = {bq[2*i+1], bq[2*i]};
      w.cyc  = 0;
      exp_q.push_back(w);
    end
    wlog.delete();
    done_armed = (abort_at < 0);
    saw_done   = 0;
    start_cyc  = cyc_n;
    load_start = 1'b1; load_base = base; load_count = cnt; load_fmt = fmt;
    cyc();
    load_start = 1'b0; load_base = ~base; load_count = '0; load_fmt = ~fmt;
    chk("busy_after_start", 32'(busy), 1);
    chk("ready_after_start", 32'(byte_in_ready), (cnt != 0) ? 1 : 0);
    k = 0;
    t = 0;
    while (!saw_done && t < 20000) begin
      if (abort_at >= 0 && k == abort_at) begin
        load_abort = 1'b1; byte_in = 8'hEE; byte_in_valid = 1'b1;
        cyc();
        load_abort = 1'b0; byte_in_valid = 1'b0;
        chk("ready_after_abort", 32'(byte_in_ready), 0);
        chk("busy_after_abort", 32'(busy), 0);
        repeat (4) cyc();
        break;
      end
      if (t == restart_at) begin
        load_start = 1'b1; load_base = 12'h0AB; load_count = 13'd2;
      end else begin
        load_start = 1'b0;
      end
      if (gap > 0 && (t % gap) == gap - 1) byte_in_valid = 1'b0;
      else if (k < bq.size()) begin byte_in = bq[k]; byte_in_valid = 1'b1; end
      else byte_in_valid = 1'b0;
      if (byte_in_valid && byte_in_ready) k++;
      cyc();
      t++;
    end
    load_start = 1'b0; byte_in_valid = 1'b0;
    if (abort_at < 0) begin
      chk("done_seen", 32'(saw_done), 1);
      chk("bytes_consumed", k, ntex * bpt);
    end
    chk("all_writes_done", 32'(exp_q.size()), 0);
    cyc();
  endtask

  logic [15:0] t1_data [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  initial begin
    // Reset state
    repeat (2) cyc();
    chk("rst_wr_addr", 32'(tex_wr_addr), 0);
    chk("rst_wr_data", 32'(tex_wr_data), 0);
    chk("rst_wr_en", 32'(tex_wr_en), 0);
    chk("rst_ready", 32'(byte_in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // T1: fmt 0, base 0, count 4, back-to-back
    bq = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
    run_load(1'b0, 12'd0, 13'd4, 0, -1, -1);
    chk("t1_nwrites", 32'(wlog.size()), 4);
    if (wlog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_addr", 32'(wlog[i].addr), i);
        chk("t1_data", 32'(wlog[i].data), 32'(t1_data[i]));
        if (i > 0) chk("t1_spacing", wlog[i].cyc - wlog[i-1].cyc, 2);
      end
      chk("t1_done_with_last", done_cyc, wlog[3].cyc);
    end
    chk("t1_done_latency", done_cyc - start_cyc, 9);

    // T2: fmt 1, base 5, count 2
    bq = '{8'hFF, 8'h80, 8'h08, 8'h00, 8'hFF, 8'h00};
    run_load(1'b1, 12'd5, 13'd2, 0, -1, -1);
    chk("t2_nwrites", 32'(wlog.size()), 2);
    if (wlog.size() == 2) begin
      chk("t2_w0", {wlog[0].addr, wlog[0].data}, {12'd5, 16'hFC01});
      chk("t2_w1", {wlog[1].addr, wlog[1].data}, {12'd6, 16'h07E0});
      chk("t2_spacing", wlog[1].cyc - wlog[0].cyc, 3);
    end

    // T3: address wrap
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_load(1'b0, 12'd4095, 13'd3, 0, -1, -1);
    chk("t3_nwrites", 32'(wlog.size()), 3);
    if (wlog.size() == 3) begin
      chk("t3_w0", {wlog[0].addr, wlog[0].data}, {12'd4095, 16'h2211});
      chk("t3_w1", {wlog[1].addr, wlog[1].data}, {12'd0, 16'h4433});
      chk("t3_w2", {wlog[2].addr, wlog[2].data}, {12'd1, 16'h6655});
    end

    // T4: valid gaps plus a start pulse while busy
    bq = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
    run_load(1'b0, 12'h010, 13'd4, 3, -1, 2);
    chk("t4_nwrites", 32'(wlog.size()), 4);
    if (wlog.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t4_data", 32'(wlog[i].data), 32'(t1_data[i]));
    end

    // T5: abort after one byte of the second texel
    run_load(1'b0, 12'd0, 13'd4, 0, 3, -1);
    chk("t5_nwrites", 32'(wlog.size()), 1);
    if (wlog.size() == 1) chk("t5_data", 32'(wlog[0].data), 32'h1234);

    // T6: zero-length load; also shows a start is accepted after the abort
    run_load(1'b0, 12'd7, 13'd0, 0, -1, -1);
    chk("t6_nwrites", 32'(wlog.size()), 0);
    chk("t6_done_latency", done_cyc - start_cyc, 1);

    // T7: count beyond texture size is clamped
    bq.delete();
    for (int i = 0; i < 8200; i++) bq.push_back(8'((i * 37) ^ (i >> 8)));
    run_load(1'b0, 12'd100, 13'd5000, 0, -1, -1);
    chk("t7_nwrites", 32'(wlog.size()), 4096);

    // T8: asynchronous reset mid-load
    bq = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
    run_load(1'b0, 12'h123, 13'd4, 0, 3, -1);   // leaves non-zero write regs
    exp_q.delete();
    load_start = 1'b1; load_base = 12'h200; load_count = 13'd4; load_fmt = 1'b0;
    cyc();
    load_start = 1'b0;
    byte_in = 8'h34; byte_in_valid = 1'b1;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_addr", 32'(tex_wr_addr), 0);
    chk("arst_wr_data", 32'(tex_wr_data), 0);
    chk("arst_wr_en", 32'(tex_wr_en), 0);
    chk("arst_ready", 32'(byte_in_ready), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    byte_in_valid = 1'b0;
    done_armed = 0;
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
